// File: rtl/timer_ctrl_if.sv
// Peripheral-bus bundle between the CPU and the interval timer.
interface timer_ctrl_if;
    logic        read;
    logic        write;
    logic [2:0]  addr;
    logic [15:0] in_bus;
    logic [15:0] out_bus;
    logic        interrupt;

    modport master (
        output read, write, addr, in_bus,
        input  out_bus, interrupt
    );

    modport slave (
        input  read, write, addr, in_bus,
        output out_bus, interrupt
    );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable interval timer: prescaler plus up-counter raising a pending
// interrupt every PERIOD ticks, with one-shot, W1C status and miss detection.
module timer_ctrl #(
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned DEFAULT_PERIOD = 50000000,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    timer_ctrl_if.slave bus
);
    localparam int unsigned HiWidth = COUNTER_WIDTH - 16;
    localparam logic [COUNTER_WIDTH-1:0] PeriodInit = COUNTER_WIDTH'(DEFAULT_PERIOD);

    logic [COUNTER_WIDTH-1:0]  counter_q, counter_d;
    logic [PRESCALE_WIDTH-1:0] prescaler_q, prescaler_d;
    logic [COUNTER_WIDTH-1:0]  period_q, period_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic                      en_q, en_d;
    logic                      oneshot_q, oneshot_d;
    logic                      irq_en_q, irq_en_d;
    logic                      pend_q, pend_d;
    logic                      miss_q, miss_d;
    logic [HiWidth-1:0]        snapshot_q, snapshot_d;
    logic [15:0]               out_bus_q, out_bus_d;
    logic                      interrupt_q;

    logic                      wr_ctrl, wr_status, wr_period_lo, wr_period_hi, wr_prescale;
    logic                      clr_pend, clr_miss;
    logic                      tick, terminal;
    logic [COUNTER_WIDTH-1:0]  period_last;

    assign wr_ctrl      = bus.write && (bus.addr == 3'd0);
    assign wr_status    = bus.write && (bus.addr == 3'd1);
    assign wr_period_lo = bus.write && (bus.addr == 3'd2);
    assign wr_period_hi = bus.write && (bus.addr == 3'd3);
    assign wr_prescale  = bus.write && (bus.addr == 3'd6);
    assign clr_pend     = wr_status && bus.in_bus[0];
    assign clr_miss     = wr_status && bus.in_bus[1];

    // PERIOD=0 behaves like PERIOD=1; >= lets a shrunk period resolve on the next tick.
    assign period_last = (period_q == '0) ? '0 : period_q - COUNTER_WIDTH'(1);
    assign tick        = en_q && (prescaler_q == prescale_q);
    assign terminal    = tick && (counter_q >= period_last);

    // Next-state for counting, control, status and the registered read port.
    always_comb begin
        counter_d   = counter_q;
        prescaler_d = prescaler_q;
        period_d    = period_q;
        prescale_d  = prescale_q;
        en_d        = en_q;
        oneshot_d   = oneshot_q;
        irq_en_d    = irq_en_q;
        snapshot_d  = snapshot_q;
        out_bus_d   = out_bus_q;

        if (en_q) begin
            if (tick) begin
                prescaler_d = '0;
                counter_d   = terminal ? '0 : counter_q + COUNTER_WIDTH'(1);
            end else begin
                prescaler_d = prescaler_q + PRESCALE_WIDTH'(1);
            end
        end

        if (terminal && oneshot_q) begin
            en_d = 1'b0;
        end

        // Set wins over a coincident clear; a cleared event cannot count as missed.
        pend_d = terminal | (pend_q & ~clr_pend);
        miss_d = (terminal & pend_q & ~clr_pend) | (miss_q & ~clr_miss);

        // Bus writes override the automatic one-shot disable.
        if (wr_ctrl) begin
            en_d      = bus.in_bus[0];
            oneshot_d = bus.in_bus[1];
            irq_en_d  = bus.in_bus[2];
            if (!en_q && bus.in_bus[0]) begin
                counter_d   = '0;
                prescaler_d = '0;
            end
        end
        if (wr_period_lo) begin
            period_d[15:0] = bus.in_bus;
        end
        if (wr_period_hi) begin
            period_d[COUNTER_WIDTH-1:16] = bus.in_bus[HiWidth-1:0];
        end
        if (wr_prescale) begin
            prescale_d = bus.in_bus[PRESCALE_WIDTH-1:0];
        end

        // Reads see pre-write register values.
        if (bus.read) begin
            case (bus.addr)
                3'd0:    out_bus_d = {13'd0, irq_en_q, oneshot_q, en_q};
                3'd1:    out_bus_d = {14'd0, miss_q, pend_q};
                3'd2:    out_bus_d = period_q[15:0];
                3'd3:    out_bus_d = 16'(period_q[COUNTER_WIDTH-1:16]);
                3'd4: begin
                    out_bus_d  = counter_q[15:0];
                    snapshot_d = counter_q[COUNTER_WIDTH-1:16];
                end
                3'd5:    out_bus_d = 16'(snapshot_q);
                3'd6:    out_bus_d = 16'(prescale_q);
                default: out_bus_d = '0;
            endcase
        end
    end

    // State registers with asynchronous reset to the free-running default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q   <= '0;
            prescaler_q <= '0;
            period_q    <= PeriodInit;
            prescale_q  <= '0;
            en_q        <= 1'b1;
            oneshot_q   <= 1'b0;
            irq_en_q    <= 1'b1;
            pend_q      <= 1'b0;
            miss_q      <= 1'b0;
            snapshot_q  <= '0;
            out_bus_q   <= '0;
            interrupt_q <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            prescaler_q <= prescaler_d;
            period_q    <= period_d;
            prescale_q  <= prescale_d;
            en_q        <= en_d;
            oneshot_q   <= oneshot_d;
            irq_en_q    <= irq_en_d;
            pend_q      <= pend_d;
            miss_q      <= miss_d;
            snapshot_q  <= snapshot_d;
            out_bus_q   <= out_bus_d;
            interrupt_q <= pend_q & irq_en_q;
        end
    end

    assign bus.out_bus   = out_bus_q;
    assign bus.interrupt = interrupt_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Randomised self-checking bench for timer_ctrl against a behavioural model.
module tb_timer_ctrl;
    localparam int unsigned DefPeriod = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    timer_ctrl_if bus ();

    timer_ctrl #(
        .COUNTER_WIDTH  (32),
        .DEFAULT_PERIOD (DefPeriod),
        .PRESCALE_WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state, plain integers.
    longint m_cnt, m_pre, m_period, m_prescale, m_snap, m_out;
    bit     m_en, m_os, m_ie, m_pend, m_miss, m_irq;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_period = DefPeriod; m_prescale = 0; m_snap = 0; m_out = 0;
        m_en = 1; m_os = 0; m_ie = 1; m_pend = 0; m_miss = 0; m_irq = 0;
    endtask

    function automatic bit model_term_next();
        longint last;
        last = (m_period == 0) ? 0 : m_period - 1;
        return m_en && (m_pre == m_prescale) && (m_cnt >= last);
    endfunction

    task automatic model_edge(input bit rd, input bit wr, input int a, input int d);
        bit tick, term, clr_p, clr_m, old_pend, old_en;
        longint last;
        last     = (m_period == 0) ? 0 : m_period - 1;
        tick     = m_en && (m_pre == m_prescale);
        term     = tick && (m_cnt >= last);
        old_pend = m_pend;
        old_en   = m_en;
        clr_p    = wr && (a == 1) && d[0];
        clr_m    = wr && (a == 1) && d[1];
        m_irq    = m_pend && m_ie;
        if (rd) begin
            case (a)
                0: m_out = m_ie * 4 + m_os * 2 + m_en;
                1: m_out = m_miss * 2 + m_pend;
                2: m_out = m_period % 65536;
                3: m_out = m_period / 65536;
                4: begin m_out = m_cnt % 65536; m_snap = m_cnt / 65536; end
                5: m_out = m_snap;
                6: m_out = m_prescale;
                default: m_out = 0;
            endcase
        end
        if (m_en) begin
            if (tick) begin
                m_pre = 0;
                m_cnt = term ? 0 : m_cnt + 1;
            end else begin
                m_pre = (m_pre + 1) % 256;
            end
        end
        m_miss = (term && old_pend && !clr_p) || (m_miss && !clr_m);
        m_pend = term || (old_pend && !clr_p);
        if (term && m_os) m_en = 0;
        if (wr) begin
            case (a)
                0: begin
                    m_en = d[0]; m_os = d[1]; m_ie = d[2];
                    if (!old_en && d[0]) begin m_cnt = 0; m_pre = 0; end
                end
                2: m_period = (m_period / 65536) * 65536 + (d % 65536);
                3: m_period = (m_period % 65536) + longint'(d % 65536) * 65536;
                6: m_prescale = d % 256;
                default: ;
            endcase
        end
    endtask

    // One bus cycle: drive, clock, update model, check.
    task automatic step(input bit rd, input bit wr, input int a, input int d);
        bus.read   = rd;
        bus.write  = wr;
        bus.addr   = 3'(a);
        bus.in_bus = 16'(d);
        @(posedge clk);
        model_edge(rd, wr, a, d);
        #1;
        check("interrupt", bus.interrupt, m_irq);
        if (rd) check($sformatf("read_addr%0d", a), bus.out_bus, m_out);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic wr_reg(input int a, input int d);
        step(0, 1, a, d);
    endtask

    task automatic rd_reg(input int a);
        step(1, 0, a, 0);
    endtask

    initial begin
        int first_irq;
        bit hit;
        bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.in_bus = '0;
        model_reset();
        #12;
        check("reset_interrupt", bus.interrupt, 0);
        check("reset_out_bus", bus.out_bus, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default free-running period.
        first_irq = 0;
        for (int n = 1; n <= 700; n++) begin
            step(0, 0, 0, 0);
            if (first_irq == 0 && bus.interrupt === 1'b1) first_irq = n;
        end
        check("first_irq_cycle", first_irq, DefPeriod + 1);
        rd_reg(0); check("reset_ctrl", bus.out_bus, 5);
        rd_reg(2); rd_reg(3); rd_reg(6); rd_reg(1);

        // Short period with prescaler.
        wr_reg(0, 0); wr_reg(1, 3); wr_reg(3, 0); wr_reg(2, 10); wr_reg(6, 3);
        wr_reg(0, 5);
        for (int i = 0; i < 30; i++) begin
            rd_reg(4); idle(3);
            if (i % 10 == 9) wr_reg(1, 1);
        end

        // One-shot.
        wr_reg(0, 0); wr_reg(6, 0); wr_reg(2, 5); wr_reg(1, 3);
        wr_reg(0, 7); idle(8);
        rd_reg(0); check("oneshot_ctrl", bus.out_bus, 6);
        rd_reg(1); rd_reg(4); idle(4); rd_reg(4);

        // Missed event, then clear on the exact terminal cycle.
        wr_reg(1, 3); wr_reg(0, 5); idle(12);
        rd_reg(1); check("miss_status", bus.out_bus, 3);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (model_term_next()) begin wr_reg(1, 3); hit = 1; end
            else idle(1);
        end
        check("race_found", hit, 1);
        rd_reg(1); check("race_status", bus.out_bus, 1);

        // Period shrink while counter sits at 30.
        wr_reg(0, 0); wr_reg(2, 100); wr_reg(1, 3); wr_reg(0, 5);
        idle(30);
        wr_reg(2, 8);
        rd_reg(4); check("shrink_count_a", bus.out_bus, 31);
        rd_reg(4); check("shrink_count_b", bus.out_bus, 0);
        rd_reg(1);

        // Snapshot consistency across the 16-bit boundary.
        wr_reg(0, 0); wr_reg(3, 4); wr_reg(2, 0); wr_reg(1, 3); wr_reg(0, 1);
        for (int i = 0; i < 70000 && m_cnt < 'hFFF8; i++) idle(1);
        check("snap_reached", m_cnt, 'hFFF8);
        for (int i = 0; i < 8; i++) begin rd_reg(4); rd_reg(5); end
        check("snap_hi_after_roll", bus.out_bus, 1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int a, d;
            bit rd, wr;
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 3) == 0);
            a  = $urandom_range(0, 7);
            case (a)
                2:       d = $urandom_range(0, 40);
                3:       d = ($urandom_range(0, 7) == 0) ? 1 : 0;
                6:       d = $urandom_range(0, 3);
                default: d = $urandom_range(0, 65535);
            endcase
            step(rd, wr, a, d);
        end

        // Asynchronous reset mid-count with an interrupt asserted.
        wr_reg(0, 0); wr_reg(3, 0); wr_reg(2, 3); wr_reg(6, 0); wr_reg(1, 3);
        wr_reg(0, 5); idle(10);
        rd_reg(0);
        check("pre_reset_irq", bus.interrupt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_irq", bus.interrupt, 0);
        check("async_out_bus", bus.out_bus, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(5);
        rd_reg(4); check("restart_count", bus.out_bus, 5);
        rd_reg(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
